// File: rtl/adc_cfg_pkg.sv
// Shared state encoding, table entry layout and the default ADC register
// init table used by the configuration sequencer.
package adc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } seq_state_t;

    typedef struct packed {
        logic [7:0] regAddr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam int TABLE_DEPTH = 8;

    // Entry 0 sits in the least significant slot so the index maps directly.
    localparam cfg_entry_t [TABLE_DEPTH-1:0] ADC_INIT_TABLE = {
        16'h0010,
        16'h0203,
        16'h0100,
        16'h0201,
        16'h0482,
        16'h0300,
        16'h1A11,
        16'h1D00
    };

endpackage

// File: rtl/adc_cfg_rom.sv
// Registered lookup into the ADC init table; the entry appears one clk after
// a read of the index and then holds until the next read.
module adc_cfg_rom
    import adc_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rdEn,
    input  logic [3:0] i_index,
    output cfg_entry_t o_entry
);

    cfg_entry_t r_entry;
    logic [4:0] w_indexWide;

    assign w_indexWide = {1'b0, i_index};

    // Indices past the configured or stored table length read back as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_entry <= '0;
        end else if (i_rdEn) begin
            if ((w_indexWide < 5'(NUM_ENTRIES)) && (w_indexWide < 5'(TABLE_DEPTH)))
                r_entry <= ADC_INIT_TABLE[i_index[2:0]];
            else
                r_entry <= '0;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Walks the ADC init table and issues each entry as a single-register I2C
// write, with NACK retry, response timeout and an inter-transaction gap.
module adc_cfg_sequencer
    import adc_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES    = 8,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 2000000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [6:0] dev_addr,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    input  logic       wr_nack
);

    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0]    LAST_INDEX   = 4'(NUM_ENTRIES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t    r_state;
    seq_state_t    w_nextState;
    logic [3:0]    r_index;
    logic [RW-1:0] r_retryCnt;
    logic [GW-1:0] r_gapCnt;
    logic [TW-1:0] r_toCnt;
    logic [6:0]    r_devAddr;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [3:0]    r_errIndex;

    logic          w_accept;
    logic          w_ack;
    logic          w_timeout;
    logic          w_failAttempt;
    logic [RW-1:0] w_retryNext;
    logic          w_romRdEn;
    logic          w_handshake;
    cfg_entry_t    w_romEntry;

    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_ack         = wr_done && !wr_nack;
    assign w_timeout     = (r_toCnt == TIMEOUT_LAST);
    assign w_failAttempt = (wr_done && wr_nack) || (!wr_done && w_timeout);
    assign w_retryNext   = r_retryCnt + RW'(1);
    assign w_romRdEn     = (r_state == ST_FETCH);
    assign w_handshake   = wr_valid && wr_ready;

    adc_cfg_rom #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_rom (
        .clk     (clk),
        .reset   (reset),
        .i_rdEn  (w_romRdEn),
        .i_index (r_index),
        .o_entry (w_romEntry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_nextState;
    end

    // A response in the same cycle as the timeout wins, and abort overrides both.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:
                if (start) w_nextState = ST_FETCH;
            ST_FETCH:
                w_nextState = abort ? ST_FAIL : ST_ISSUE;
            ST_ISSUE:
                if (abort)         w_nextState = ST_FAIL;
                else if (wr_ready) w_nextState = ST_WAIT_RESP;
            ST_WAIT_RESP:
                if (abort)
                    w_nextState = ST_FAIL;
                else if (w_ack)
                    w_nextState = (r_index == LAST_INDEX) ? ST_DONE : ST_GAP;
                else if (w_failAttempt)
                    w_nextState = (w_retryNext == RETRY_LIMIT) ? ST_FAIL : ST_GAP;
            ST_GAP:
                if (abort)                      w_nextState = ST_FAIL;
                else if (r_gapCnt == GAP_LAST)  w_nextState = ST_FETCH;
            ST_DONE, ST_FAIL:
                w_nextState = ST_IDLE;
            default:
                w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index    <= '0;
            r_retryCnt <= '0;
            r_gapCnt   <= '0;
            r_toCnt    <= '0;
            r_devAddr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_errIndex <= '0;
        end else begin
            r_busy <= (w_nextState == ST_FETCH) || (w_nextState == ST_ISSUE) ||
                      (w_nextState == ST_WAIT_RESP) || (w_nextState == ST_GAP);

            if (w_accept) begin
                r_devAddr  <= dev_addr;
                r_index    <= '0;
                r_retryCnt <= '0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
            end

            if ((r_state == ST_WAIT_RESP) && !abort) begin
                if (w_ack) begin
                    r_retryCnt <= '0;
                    if (r_index != LAST_INDEX)
                        r_index <= r_index + 4'd1;
                end else if (w_failAttempt) begin
                    r_retryCnt <= w_retryNext;
                end
            end

            r_gapCnt <= (r_state == ST_GAP) ? r_gapCnt + GW'(1) : '0;

            if ((r_state == ST_ISSUE) && w_handshake)
                r_toCnt <= '0;
            else if ((r_state == ST_WAIT_RESP) && !w_timeout)
                r_toCnt <= r_toCnt + TW'(1);

            if ((w_nextState == ST_DONE) && (r_state != ST_DONE))
                r_done <= 1'b1;

            if ((w_nextState == ST_FAIL) && (r_state != ST_FAIL)) begin
                r_error    <= 1'b1;
                r_errIndex <= r_index;
            end
        end
    end

    // Abort gates the request combinationally so a pending handshake cannot complete.
    assign wr_valid  = (r_state == ST_ISSUE) && !abort;
    assign wr_addr   = r_devAddr;
    assign wr_reg    = w_romEntry.regAddr;
    assign wr_data   = w_romEntry.data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_index = r_errIndex;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Bench for adc_cfg_sequencer: a behavioural I2C write engine plus a table of
// run scenarios and hand-written abort, reset and start-while-busy sequences.
module tb_adc_cfg_sequencer;

    localparam int GAP = 500;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] dev_addr = 7'h4C;
    logic       busy, done, error, wr_valid;
    logic [3:0] err_index;
    logic       wr_ready = 1'b0;
    logic [6:0] wr_addr;
    logic [7:0] wr_reg, wr_data;
    logic       wr_done = 1'b0;
    logic       wr_nack = 1'b0;

    int total = 0;
    int bad = 0;

    // Engine model configuration and request log
    logic [15:0] nackKey;
    int          nackLimit;
    int          nackUsed;
    bit          muteEn;
    logic [15:0] muteKey;
    bit          curNack, curMute, pending, seenDone;
    int          engCnt, respCnt, cycle, lastDoneCycle, minGap, reqCount;
    logic [15:0] reqLog [64];
    logic [6:0]  addrLog [64];
    int          reqCycle [64];

    logic [15:0] tbTable [8] = '{16'h1D00, 16'h1A11, 16'h0300, 16'h0482,
                                 16'h0201, 16'h0100, 16'h0203, 16'h0010};
    logic [15:0] expSeq [64];
    int          expCount;

    typedef struct {
        string       name;
        logic [15:0] nackKey;
        int          nackLimit;
        bit          muteEn;
        logic [15:0] muteKey;
        bit          expDone;
        bit          expError;
        logic [3:0]  expErrIdx;
        int          expReqs;
    } vec_t;

    vec_t vecs [4];

    adc_cfg_sequencer #(
        .NUM_ENTRIES    (8),
        .MAX_RETRY      (3),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .dev_addr  (dev_addr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack)
    );

    always #10 clk = ~clk;

    // Engine: accepts on the second cycle of wr_valid, answers 20 cycles later
    always @(negedge clk) begin
        cycle++;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        wr_nack  = 1'b0;
        if (!reset) begin
            engCnt  = 0;
            respCnt = 0;
            pending = 1'b0;
        end else if (pending) begin
            respCnt++;
            if (respCnt == 20) begin
                pending = 1'b0;
                if (!curMute) begin
                    wr_done       = 1'b1;
                    wr_nack       = curNack;
                    lastDoneCycle = cycle;
                    seenDone      = 1'b1;
                end
            end
        end else if (wr_valid) begin
            engCnt++;
            if (engCnt == 1 && seenDone && (cycle - lastDoneCycle) < minGap)
                minGap = cycle - lastDoneCycle;
            if (engCnt == 2) begin
                wr_ready = 1'b1;
                engCnt   = 0;
                pending  = 1'b1;
                respCnt  = 0;
                if (reqCount < 64) begin
                    reqLog[reqCount]   = {wr_reg, wr_data};
                    addrLog[reqCount]  = wr_addr;
                    reqCycle[reqCount] = cycle;
                end
                reqCount++;
                curMute = muteEn && ({wr_reg, wr_data} == muteKey);
                curNack = 1'b0;
                if (({wr_reg, wr_data} == nackKey) && (nackUsed < nackLimit)) begin
                    curNack = 1'b1;
                    nackUsed++;
                end
            end
        end else begin
            engCnt = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic configEngine(input logic [15:0] nk, input int nl, input bit me, input logic [15:0] mk);
        nackKey   = nk;
        nackLimit = nl;
        nackUsed  = 0;
        muteEn    = me;
        muteKey   = mk;
        reqCount  = 0;
        seenDone  = 1'b0;
        minGap    = 1 << 30;
    endtask

    // Reference request sequence from the table and the engine's NACK rules
    task automatic buildExpected(input logic [15:0] nk, input int nl, input bit me, input logic [15:0] mk);
        int used;
        int tries;
        bit ok;
        used = 0;
        expCount = 0;
        for (int e = 0; e < 8; e++) begin
            tries = 0;
            ok = 1'b0;
            while (!ok && tries < 3) begin
                expSeq[expCount] = tbTable[e];
                expCount++;
                if (me && tbTable[e] == mk) tries++;
                else if (tbTable[e] == nk && used < nl) begin used++; tries++; end
                else ok = 1'b1;
            end
            if (!ok) return;
        end
    endtask

    task automatic waitDone(output bit finished, output bit prevBusy);
        finished = 1'b0;
        prevBusy = 1'b0;
        for (int k = 0; k < 8000 && !finished; k++) begin
            prevBusy = busy;
            tick();
            if (done || error) finished = 1'b1;
        end
    endtask

    task automatic waitReqs(input int n);
        for (int k = 0; k < 3000 && reqCount < n; k++) tick();
        if (reqCount < n) checkOutput("reqWait", reqCount, n);
    endtask

    task automatic checkSequence(input string tag);
        for (int i = 0; i < expCount; i++)
            checkOutput($sformatf("%s req%0d", tag, i), {addrLog[i], reqLog[i]}, {7'h4C, expSeq[i]});
    endtask

    task automatic runVector(input vec_t v);
        bit finished, prevBusy;
        configEngine(v.nackKey, v.nackLimit, v.muteEn, v.muteKey);
        buildExpected(v.nackKey, v.nackLimit, v.muteEn, v.muteKey);
        applyStimulus();
        waitDone(finished, prevBusy);
        checkOutput({v.name, " finished"}, finished, 1);
        checkOutput({v.name, " done"}, done, v.expDone);
        checkOutput({v.name, " error"}, error, v.expError);
        checkOutput({v.name, " busyFall"}, {prevBusy, busy}, 2'b10);
        if (v.expError) checkOutput({v.name, " errIdx"}, err_index, v.expErrIdx);
        checkOutput({v.name, " reqCount"}, reqCount, v.expReqs);
        checkSequence(v.name);
        if (v.muteEn) begin
            for (int i = 1; i < 3; i++)
                checkOutput($sformatf("%s spacing%0d", v.name, i),
                            (reqCycle[i] - reqCycle[i-1]) >= (TMO + GAP), 1);
        end else begin
            checkOutput({v.name, " gap"}, minGap >= GAP, 1);
        end
        repeat (5) tick();
    endtask

    initial begin
        bit finished, prevBusy;

        vecs[0] = '{"nominal",  16'hFFFF, 0,   1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 8};
        vecs[1] = '{"nackOnce", 16'h0482, 1,   1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 9};
        vecs[2] = '{"exhaust",  16'h0100, 100, 1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd5, 8};
        vecs[3] = '{"timeout",  16'hFFFF, 0,   1'b1, 16'h1D00, 1'b0, 1'b1, 4'd0, 3};

        configEngine(16'hFFFF, 0, 1'b0, 16'hFFFF);
        tick();
        tick();
        checkOutput("resetState", {busy, done, error, err_index, wr_valid, wr_addr, wr_reg, wr_data}, 0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) runVector(vecs[v]);

        // Abort while waiting on entry 2's response, then restart cleanly
        configEngine(16'hFFFF, 0, 1'b0, 16'hFFFF);
        applyStimulus();
        waitReqs(3);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortWait state", {error, done, busy, wr_valid}, 4'b1000);
        checkOutput("abortWait errIdx", err_index, 4'd2);
        repeat (30) tick();
        checkOutput("abortWait sticky", error, 1);
        configEngine(16'hFFFF, 0, 1'b0, 16'hFFFF);
        buildExpected(16'hFFFF, 0, 1'b0, 16'hFFFF);
        applyStimulus();
        checkOutput("restart errClr", error, 0);
        waitDone(finished, prevBusy);
        checkOutput("restart done", {finished, done, error}, 3'b110);
        checkOutput("restart reqCount", reqCount, 8);
        checkSequence("restart");
        repeat (5) tick();

        // Abort during ISSUE drops wr_valid in the same cycle
        configEngine(16'hFFFF, 0, 1'b0, 16'hFFFF);
        applyStimulus();
        for (int k = 0; k < 50 && !wr_valid; k++) tick();
        checkOutput("issue reached", wr_valid, 1);
        #1 abort = 1'b1;
        #1 checkOutput("abortIssue validDrop", wr_valid, 0);
        tick();
        abort = 1'b0;
        checkOutput("abortIssue state", {error, busy, err_index}, {1'b1, 1'b0, 4'd0});
        repeat (30) tick();

        // Asynchronous reset mid-ISSUE clears every output without a clock edge
        configEngine(16'hFFFF, 0, 1'b0, 16'hFFFF);
        applyStimulus();
        for (int k = 0; k < 50 && !wr_valid; k++) tick();
        checkOutput("preReset valid", wr_valid, 1);
        #1 reset = 1'b0;
        #1 checkOutput("asyncReset", {busy, done, error, err_index, wr_valid, wr_addr, wr_reg, wr_data}, 0);
        tick();
        reset = 1'b1;
        tick();

        // Start pulses while busy are ignored; abort in IDLE does nothing
        configEngine(16'hFFFF, 0, 1'b0, 16'hFFFF);
        buildExpected(16'hFFFF, 0, 1'b0, 16'hFFFF);
        applyStimulus();
        waitReqs(2);
        applyStimulus();
        waitReqs(5);
        repeat (100) tick();
        applyStimulus();
        waitDone(finished, prevBusy);
        checkOutput("busyStart done", {finished, done, error}, 3'b110);
        checkOutput("busyStart reqCount", reqCount, 8);
        checkSequence("busyStart");
        repeat (3) tick();
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        checkOutput("idleAbort", {done, error, busy}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
